ddr5_pwrgd_fail_detect: RTL and testbench

- Upstream stage of the DDR5 PWRGD/FAIL LED latch.
- Monitors the raw per-memory-controller DDR5 PWRGD pins while the sequencer has DIMM power enabled, and flags each channel that fails to come up in time or drops after coming up.
- Produces the per-channel fault vector (consumed as iCpuMemFlt by the LED latch), an aggregate fault, and the aggregate memory power-good returned to the sequencer.

---
 rtl/ddr5_pwrgd_pkg.sv | 20 ++
 rtl/ddr5_pwrgd_ch_mon.sv | 96 +++++++++
 rtl/ddr5_pwrgd_fail_detect.sv | 51 +++++
 tb/tb_ddr5_pwrgd_fail_detect.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr5_pwrgd_pkg.sv
// Shared definitions for the DDR5 PWRGD fail detector: channel state encoding,
// default timing parameters and a counter width helper.
package ddr5_pwrgd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_PG = 2'd1,
        ST_PG_OK   = 2'd2,
        ST_FAULT   = 2'd3
    } chState_t;

    localparam int DEF_DEBOUNCE_CYC = 4;
    localparam int DEF_TIMEOUT_CYC  = 2000;

    // Bits needed for a counter that runs 0 .. numVals-1 (never less than 1).
    function automatic int cntWidth(input int numVals);
        return (numVals <= 2) ? 1 : $clog2(numVals);
    endfunction

endpackage

// File: rtl/ddr5_pwrgd_ch_mon.sv
// One memory-controller channel: PWRGD synchronizer, debounce filter, bring-up
// timer and the IDLE/WAIT_PG/PG_OK/FAULT supervisor.
module ddr5_pwrgd_ch_mon
    import ddr5_pwrgd_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic iClk,
    input  logic iRst_n,
    input  logic iMemPwrEn,
    input  logic iPwrgdRaw,
    input  logic iFltClr,
    output logic oFltNxt,
    output logic oOkNxt
);

    localparam int DW = cntWidth(DEBOUNCE_CYC);
    localparam int TW = cntWidth(TIMEOUT_CYC);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYC - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] TMR_MAX  = '1;

    logic          pgMeta;
    logic          pgSync;
    logic          pgFilt;
    logic [DW-1:0] debCnt;

    // NOTE: every flop is written with <= so all registers update from pre-edge values.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            pgMeta <= 1'b0;
            pgSync <= 1'b0;
            pgFilt <= 1'b0;
            debCnt <= '0;
        end else begin
            pgMeta <= iPwrgdRaw;
            pgSync <= pgMeta;
            if (pgSync == pgFilt) begin
                debCnt <= '0;
            end else if (debCnt == DEB_LAST) begin
                pgFilt <= pgSync;
                debCnt <= '0;
            end else begin
                debCnt <= debCnt + 1'b1;
            end
        end
    end

    chState_t      state;
    chState_t      stateNxt;
    logic [TW-1:0] timer;

    // NOTE: stateNxt is defaulted first so no path through the case infers a latch.
    always_comb begin
        stateNxt = state;
        case (state)
            ST_IDLE: begin
                if (iMemPwrEn) stateNxt = ST_WAIT_PG;
            end
            ST_WAIT_PG: begin
                // A good PWRGD in the timeout cycle wins over the timeout.
                if (!iMemPwrEn)             stateNxt = ST_IDLE;
                else if (pgFilt)            stateNxt = ST_PG_OK;
                else if (timer == TMO_LAST) stateNxt = ST_FAULT;
            end
            ST_PG_OK: begin
                // Enable dropping with PWRGD is a normal power-down.
                if (!iMemPwrEn)   stateNxt = ST_IDLE;
                else if (!pgFilt) stateNxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (iFltClr && !iMemPwrEn) stateNxt = ST_IDLE;
            end
            default: stateNxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state <= ST_IDLE;
            timer <= '0;
        end else begin
            state <= stateNxt;
            if (state != ST_WAIT_PG) begin
                timer <= '0;
            end else if (timer != TMR_MAX) begin
                timer <= timer + 1'b1;
            end
        end
    end

    assign oFltNxt = (stateNxt == ST_FAULT);
    assign oOkNxt  = (stateNxt == ST_PG_OK);

endmodule

// File: rtl/ddr5_pwrgd_fail_detect.sv
// Per-channel DDR5 PWRGD supervision with registered per-channel fault vector,
// aggregate fault and aggregate memory power-good.
module ddr5_pwrgd_fail_detect
    import ddr5_pwrgd_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iMemPwrEn,
    input  logic [NUM_CH-1:0] iMemPwrgd,
    input  logic              iFltClr,
    output logic [NUM_CH-1:0] oCpuMemFlt,
    output logic              oMemPwrFlt,
    output logic              oMemPwrgd
);

    logic [NUM_CH-1:0] fltNxt;
    logic [NUM_CH-1:0] okNxt;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : gCh
        ddr5_pwrgd_ch_mon #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .TIMEOUT_CYC  (TIMEOUT_CYC)
        ) uChMon (
            .iClk      (iClk),
            .iRst_n    (iRst_n),
            .iMemPwrEn (iMemPwrEn),
            .iPwrgdRaw (iMemPwrgd[gi]),
            .iFltClr   (iFltClr),
            .oFltNxt   (fltNxt[gi]),
            .oOkNxt    (okNxt[gi])
        );
    end

    // Registered from next-state decodes so outputs move on the transition edge.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oCpuMemFlt <= '0;
            oMemPwrFlt <= 1'b0;
            oMemPwrgd  <= 1'b0;
        end else begin
            oCpuMemFlt <= fltNxt;
            oMemPwrFlt <= |fltNxt;
            oMemPwrgd  <= &okNxt;
        end
    end

endmodule

// File: tb/tb_ddr5_pwrgd_fail_detect.sv
// Directed plus randomized bench for ddr5_pwrgd_fail_detect, checked every cycle
// against a sliding-window / deadline reference model.
module tb_ddr5_pwrgd_fail_detect;

    localparam int NUM_CH = 4;
    localparam int DEB    = 4;
    localparam int TMO    = 2000;

    logic              iClk;
    logic              iRst_n;
    logic              iMemPwrEn;
    logic [NUM_CH-1:0] iMemPwrgd;
    logic              iFltClr;
    logic [NUM_CH-1:0] oCpuMemFlt;
    logic              oMemPwrFlt;
    logic              oMemPwrgd;

    ddr5_pwrgd_fail_detect #(
        .NUM_CH       (NUM_CH),
        .DEBOUNCE_CYC (DEB),
        .TIMEOUT_CYC  (TMO)
    ) dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iMemPwrEn  (iMemPwrEn),
        .iMemPwrgd  (iMemPwrgd),
        .iFltClr    (iFltClr),
        .oCpuMemFlt (oCpuMemFlt),
        .oMemPwrFlt (oMemPwrFlt),
        .oMemPwrgd  (oMemPwrgd)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int nChk  = 0;
    int nPass = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChk++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference model: phase per channel, a deadline cycle for bring-up, and a
    // filtered level derived from the window of the last DEB synchronized pin samples.
    typedef enum {M_OFF, M_WAIT, M_GOOD, M_FAULT} mSt_t;

    mSt_t              mSt[NUM_CH];
    int                mDeadline[NUM_CH];
    logic              mFilt[NUM_CH];
    logic [NUM_CH-1:0] pinLog[$];
    logic [NUM_CH-1:0] expFlt;
    logic              expPwrgd;
    logic              expPwrFlt;
    int                cyc = 0;

    task automatic modelReset();
        pinLog.delete();
        for (int k = 0; k < DEB + 2; k++) pinLog.push_back('0);
        for (int i = 0; i < NUM_CH; i++) begin
            mSt[i]       = M_OFF;
            mFilt[i]     = 1'b0;
            mDeadline[i] = 0;
        end
        expFlt    = '0;
        expPwrgd  = 1'b0;
        expPwrFlt = 1'b0;
    endtask

    task automatic modelEdge();
        int   last;
        logic allDiff;
        pinLog.push_back(iMemPwrgd);
        // Pin value present at this edge is last+2; the synchronized sample is two edges older.
        last = pinLog.size() - 3;
        for (int i = 0; i < NUM_CH; i++) begin
            case (mSt[i])
                M_OFF: if (iMemPwrEn) begin
                    mSt[i]       = M_WAIT;
                    mDeadline[i] = cyc + TMO;
                end
                M_WAIT: begin
                    if (!iMemPwrEn)              mSt[i] = M_OFF;
                    else if (mFilt[i])           mSt[i] = M_GOOD;
                    else if (cyc == mDeadline[i]) mSt[i] = M_FAULT;
                end
                M_GOOD: begin
                    if (!iMemPwrEn)     mSt[i] = M_OFF;
                    else if (!mFilt[i]) mSt[i] = M_FAULT;
                end
                M_FAULT: if (iFltClr && !iMemPwrEn) mSt[i] = M_OFF;
            endcase
            allDiff = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                if (pinLog[last - j][i] == mFilt[i]) allDiff = 1'b0;
            end
            if (allDiff) mFilt[i] = ~mFilt[i];
        end
        while (pinLog.size() > DEB + 8) void'(pinLog.pop_front());
        expPwrgd = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            expFlt[i] = (mSt[i] == M_FAULT);
            if (mSt[i] != M_GOOD) expPwrgd = 1'b0;
        end
        expPwrFlt = |expFlt;
    endtask

    task automatic tick();
        @(posedge iClk);
        cyc++;
        if (!iRst_n) modelReset();
        else         modelEdge();
        #1;
        check("cyc_flt",    32'(oCpuMemFlt), 32'(expFlt));
        check("cyc_pwrflt", 32'(oMemPwrFlt), 32'(expPwrFlt));
        check("cyc_pwrgd",  32'(oMemPwrgd),  32'(expPwrgd));
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    int lat;

    initial begin
        iRst_n    = 1'b0;
        iMemPwrEn = 1'b0;
        iMemPwrgd = '0;
        iFltClr   = 1'b0;
        modelReset();
        #1;
        check("rst_flt",    32'(oCpuMemFlt), 32'h0);
        check("rst_pwrflt", 32'(oMemPwrFlt), 32'h0);
        check("rst_pwrgd",  32'(oMemPwrgd),  32'h0);
        ticks(3);
        iRst_n = 1'b1;
        ticks(3);

        // Normal bring-up: pins rise 100 cycles after enable.
        iMemPwrEn = 1'b1;
        ticks(100);
        iMemPwrgd = 4'hF;
        lat = 0;
        while (oMemPwrgd !== 1'b1 && lat < 50) begin tick(); lat++; end
        check("bringup_lat", 32'(lat), 32'd7);
        check("bringup_flt", 32'(oCpuMemFlt), 32'h0);

        // Glitch of 3 cycles on pin 3 is rejected.
        iMemPwrgd[3] = 1'b0;
        ticks(3);
        iMemPwrgd[3] = 1'b1;
        ticks(20);
        check("glitch3_pwrgd", 32'(oMemPwrgd), 32'd1);
        check("glitch3_flt",   32'(oCpuMemFlt), 32'h0);

        // 5 cycles low is a real drop.
        iMemPwrgd[3] = 1'b0;
        ticks(5);
        iMemPwrgd[3] = 1'b1;
        ticks(12);
        check("glitch5_flt",   32'(oCpuMemFlt), 32'h8);
        check("glitch5_pwrgd", 32'(oMemPwrgd),  32'd0);

        // Clear with enable high is ignored; with enable low it clears next cycle.
        iFltClr = 1'b1;
        tick();
        iFltClr = 1'b0;
        tick();
        check("clr_en_hi", 32'(oCpuMemFlt), 32'h8);
        iMemPwrEn = 1'b0;
        tick();
        iFltClr = 1'b1;
        tick();
        iFltClr = 1'b0;
        check("clr_en_lo", 32'(oCpuMemFlt), 32'h0);

        // Drop after good on pin 0; fault stays after the pin recovers.
        iMemPwrEn = 1'b1;
        ticks(5);
        check("regood_pwrgd", 32'(oMemPwrgd), 32'd1);
        iMemPwrgd = 4'hE;
        lat = 0;
        while (oCpuMemFlt === 4'h0 && lat < 50) begin tick(); lat++; end
        check("drop_lat",   32'(lat), 32'd7);
        check("drop_flt",   32'(oCpuMemFlt), 32'h1);
        check("drop_pwrgd", 32'(oMemPwrgd), 32'd0);
        iMemPwrgd = 4'hF;
        ticks(20);
        check("drop_sticky", 32'(oCpuMemFlt), 32'h1);
        iMemPwrEn = 1'b0;
        tick();
        iFltClr = 1'b1;
        tick();
        iFltClr = 1'b0;
        check("drop_clr", 32'(oCpuMemFlt), 32'h0);

        // Enable falls on the same cycle the filtered PWRGD falls: normal power-down.
        iMemPwrEn = 1'b1;
        ticks(5);
        check("pd_pre_pwrgd", 32'(oMemPwrgd), 32'd1);
        iMemPwrgd = 4'h0;
        ticks(6);
        iMemPwrEn = 1'b0;
        ticks(10);
        check("pd_flt",    32'(oCpuMemFlt), 32'h0);
        check("pd_pwrflt", 32'(oMemPwrFlt), 32'd0);
        check("pd_pwrgd",  32'(oMemPwrgd),  32'd0);

        // Timeout on pin 2 exactly TMO cycles after WAIT_PG entry.
        iMemPwrgd = 4'hB;
        ticks(10);
        iMemPwrEn = 1'b1;
        lat = 0;
        while (oCpuMemFlt === 4'h0 && lat < TMO + 100) begin tick(); lat++; end
        check("tmo_lat",    32'(lat - 1), 32'(TMO));
        check("tmo_flt",    32'(oCpuMemFlt), 32'h4);
        check("tmo_pwrflt", 32'(oMemPwrFlt), 32'd1);
        check("tmo_pwrgd",  32'(oMemPwrgd),  32'd0);

        // Second fault on pin 1, then asynchronous reset mid-operation.
        iMemPwrgd = 4'h9;
        ticks(10);
        check("pre_rst_flt", 32'(oCpuMemFlt), 32'h6);
        #3;
        iRst_n = 1'b0;
        #1;
        check("arst_flt",    32'(oCpuMemFlt), 32'h0);
        check("arst_pwrflt", 32'(oMemPwrFlt), 32'd0);
        check("arst_pwrgd",  32'(oMemPwrgd),  32'd0);
        iMemPwrEn = 1'b0;
        iMemPwrgd = 4'h0;
        ticks(3);
        iRst_n = 1'b1;
        ticks(5);
        iMemPwrEn = 1'b1;
        ticks(20);
        iMemPwrgd = 4'hF;
        lat = 0;
        while (oMemPwrgd !== 1'b1 && lat < 50) begin tick(); lat++; end
        check("post_rst_lat", 32'(lat), 32'd7);
        check("post_rst_flt", 32'(oCpuMemFlt), 32'h0);

        // Randomized phase: slow pin toggling with glitches, occasional enable/clear.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ($urandom_range(7) == 0) iMemPwrgd[i] = ~iMemPwrgd[i];
            end
            if ($urandom_range(127) == 0) iMemPwrEn = ~iMemPwrEn;
            iFltClr = ($urandom_range(15) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", nPass, nChk);
        $finish;
    end

endmodule
